// File: rtl/keypad_scanner.sv
// Row-scanning keypad controller: drives one row at a time, debounces presses and
// releases, and queues press/release events in a small FIFO for the consumer.
//
// state      | meaning
// S_SCAN     | drive current row, wait SETTLE cycles, sample columns
// S_DEBOUNCE | key seen; wait for DEBOUNCE consecutive matching samples
// S_HELD     | press accepted; wait for DEBOUNCE consecutive empty samples
module keypad_scanner #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SETTLE   = 4,
    parameter int DEBOUNCE = 16000,
    parameter int DEPTH    = 8,
    localparam int CW      = $clog2(ROWS * COLS),
    localparam int EW      = CW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [COLS-1:0] scan_in,
    output logic [ROWS-1:0] scan_out,
    output logic [EW-1:0]   ev_data,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic            irq,
    output logic            overflow,
    input  logic            ovf_clr
);

    localparam int RW  = $clog2(ROWS);
    localparam int CLW = $clog2(COLS);
    localparam int SW  = $clog2(SETTLE + 1);
    localparam int DW  = $clog2(DEBOUNCE + 1);
    localparam int AW  = $clog2(DEPTH);
    localparam int CTW = AW + 1;

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_HELD
    } state_t;

    state_t          state, state_next;
    logic [RW-1:0]   row_idx, row_next, row_adv;
    logic [SW-1:0]   settle_cnt, settle_next;
    logic [DW-1:0]   deb_cnt, deb_next, deb_inc;
    logic [CW-1:0]   key_code, key_next, sample_code;
    logic [CLW-1:0]  col_hit;
    logic            any_hit;
    logic            push;
    logic [EW-1:0]   push_data;

    // Highest set column wins when several keys on the row are closed.
    always_comb begin
        col_hit = '0;
        for (int c = 0; c < COLS; c++) begin
            if (scan_in[c]) col_hit = CLW'(c);
        end
    end

    assign any_hit     = |scan_in;
    assign sample_code = CW'(int'(row_idx) * COLS + int'(col_hit));
    assign row_adv     = (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + 1'b1;
    assign deb_inc     = (deb_cnt == DW'(DEBOUNCE)) ? deb_cnt : deb_cnt + 1'b1;
    assign scan_out    = ROWS'(1) << row_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_SCAN;
            row_idx    <= '0;
            settle_cnt <= '0;
            deb_cnt    <= '0;
            key_code   <= '0;
        end else begin
            state      <= state_next;
            row_idx    <= row_next;
            settle_cnt <= settle_next;
            deb_cnt    <= deb_next;
            key_code   <= key_next;
        end
    end

    always_comb begin
        state_next  = state;
        row_next    = row_idx;
        settle_next = settle_cnt;
        deb_next    = deb_cnt;
        key_next    = key_code;
        push        = 1'b0;
        push_data   = '0;
        case (state)
            S_SCAN: begin
                if (settle_cnt == SW'(SETTLE - 1)) begin
                    settle_next = '0;
                    if (any_hit) begin
                        key_next   = sample_code;
                        deb_next   = '0;
                        state_next = S_DEBOUNCE;
                    end else begin
                        row_next = row_adv;
                    end
                end else begin
                    settle_next = settle_cnt + 1'b1;
                end
            end
            S_DEBOUNCE: begin
                if (!any_hit || sample_code != key_code) begin
                    state_next  = S_SCAN;
                    settle_next = '0;
                    deb_next    = '0;
                end else if (deb_inc == DW'(DEBOUNCE)) begin
                    push       = 1'b1;
                    push_data  = {1'b0, key_code};
                    state_next = S_HELD;
                    deb_next   = '0;
                end else begin
                    deb_next = deb_inc;
                end
            end
            S_HELD: begin
                // Any closure on the held row, even a different key, keeps it held.
                if (any_hit) begin
                    deb_next = '0;
                end else if (deb_inc == DW'(DEBOUNCE)) begin
                    push        = 1'b1;
                    push_data   = {1'b1, key_code};
                    state_next  = S_SCAN;
                    row_next    = row_adv;
                    settle_next = '0;
                    deb_next    = '0;
                end else begin
                    deb_next = deb_inc;
                end
            end
            default: begin
                state_next  = S_SCAN;
                settle_next = '0;
                deb_next    = '0;
            end
        endcase
    end

    logic [EW-1:0]  mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CTW-1:0] count;
    logic           full, pop, do_push, drop;

    assign full     = (count == CTW'(DEPTH));
    assign ev_valid = (count != '0);
    assign pop      = ev_valid & ev_ready;
    assign do_push  = push & (~full | pop);
    assign drop     = push & full & ~pop;
    assign ev_data  = ev_valid ? mem[rd_ptr] : '0;
    assign irq      = ev_valid;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter ROWS, default 4: number of driven scan rows, 2..8.
REQ-002 Parameter COLS, default 4: number of sensed columns, 2..8.
REQ-003 Parameter SETTLE, default 4: cycles a row is driven before its columns are sampled, >=1.
REQ-004 Parameter DEBOUNCE, default 16000: consecutive stable samples required to accept a press or release, >=2.
REQ-005 Parameter DEPTH, default 8: event FIFO depth, power of 2, >=2.
REQ-006 Derived CW = clog2(ROWS*COLS): key-code width; event width EW = CW+1.
REQ-007 clk  input  1  single clock; all logic on rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 scan_in  input  COLS  column sense lines, active-high (1 = key closed on the driven row).
REQ-010 scan_out  output  ROWS  one-hot row drive.
REQ-011 ev_data  output  EW  head event: bit CW = release flag (0 press, 1 release); bits CW-1:0 = key code.
REQ-012 ev_valid  output  1  FIFO not empty; ev_data is valid.
REQ-013 ev_ready  input  1  consumer accepts head event when ev_valid & ev_ready.
REQ-014 irq  output  1  active-high level, equals ev_valid.
REQ-015 overflow  output  1  sticky flag: an event was dropped.
REQ-016 ovf_clr  input  1  single-cycle pulse clearing overflow.

Function
REQ-017 Key code = row_index*COLS + col_index; with several columns set, the highest set col_index wins.
REQ-018 FSM states SCAN, DEBOUNCE, HELD; scan_out always one-hot; the row changes only in SCAN.
REQ-019 SCAN: drive the current row for SETTLE cycles, then sample scan_in. If scan_in==0, advance the row (ROWS-1 wraps to 0) and restart SETTLE. If scan_in!=0, latch the code and enter DEBOUNCE on the same row.
REQ-020 DEBOUNCE: each cycle, compare the sampled code with the latched code. On a mismatch or scan_in==0, return to SCAN on the same row with SETTLE restarted. After DEBOUNCE consecutive matches, push a press event and enter HELD.
REQ-021 HELD: stay on the row. After DEBOUNCE consecutive cycles of scan_in==0, push a release event carrying the latched code and enter SCAN on the next row. Any nonzero sample restarts the count; a code change while held is ignored.
REQ-022 Exactly one press and one release event per accepted keystroke; no event for bounces shorter than DEBOUNCE.
REQ-023 FIFO: a push becomes visible on ev_data/ev_valid the cycle after the push edge. A pop occurs on ev_valid & ev_ready, and the next entry appears the following cycle.
REQ-024 Push when full with no pop in the same cycle: drop the event, set overflow, leave FIFO contents unchanged.
REQ-025 Push and pop in the same cycle when full: both proceed, no overflow. Pop on an empty FIFO is ignored.
REQ-026 ovf_clr clears overflow. If ovf_clr coincides with a dropped push, overflow stays set.
REQ-027 The debounce counter saturates at DEBOUNCE and never wraps; width is clog2(DEBOUNCE+1).

Reset
REQ-028 While rst=1 at the clock edge: scan_out = 1 (row 0), state SCAN, SETTLE and debounce counters 0, FIFO empty, ev_valid=0, irq=0, overflow=0, ev_data=0.
REQ-029 Reset mid-debounce or mid-hold discards the pending keystroke; no release event is generated for a key held across reset.

Verification (ROWS=4, COLS=4, SETTLE=2, DEBOUNCE=4, DEPTH=4)
REQ-030 Idle scan: scan_in=0 -> scan_out cycles 1,2,4,8,1,... each held SETTLE cycles; ev_valid stays 0.
REQ-031 Press: hold scan_in=4'b0100 while row 2 is driven for 10 cycles, then 0 -> events {0,10} then {1,10}; irq high while non-empty.
REQ-032 Bounce: scan_in=4'b0001 on row 1 for 3 cycles, then 0 -> no event; scan resumes.
REQ-033 Multi-key: scan_in=4'b1010 on row 3 -> code 15 (highest column wins).
REQ-034 Overflow: ev_ready=0, 3 keystrokes (6 events) -> FIFO holds the first 4, overflow=1; ovf_clr -> overflow=0; full push coinciding with a pop -> no overflow.
REQ-035 rst asserted during HELD -> scan_out=1, FIFO empty, no release event after reset.
